// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg
// Shared types for the registered TLB: the page-group struct (pfn/c/d/v), the
// dual-page entry struct, and the default field widths. The top-level width
// parameters default to these constants and must stay equal to them, because
// entry storage is built from the structs below.
// -----------------------------------------------------------------------------
package tlb_pkg;

    localparam int TLB_C_W    = 3;   // cache-attribute field width
    localparam int TLB_VPN2_W = 19;
    localparam int TLB_ASID_W = 8;
    localparam int TLB_PFN_W  = 20;

    typedef struct packed {
        logic [TLB_PFN_W-1:0] pfn;
        logic [TLB_C_W-1:0]   c;
        logic                 d;
        logic                 v;
    } tlb_page_t;

    typedef struct packed {
        logic [TLB_VPN2_W-1:0] vpn2;
        logic [TLB_ASID_W-1:0] asid;
        logic                  g;
        tlb_page_t             p0;
        tlb_page_t             p1;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_match_enc.sv
// -----------------------------------------------------------------------------
// tlb_match_enc
// Reduces a per-entry match vector to a search result.
//   match_i : one bit per TLB entry, 1 = entry matched
//   found_o : at least one bit set
//   multi_o : two or more bits set
//   index_o : lowest set bit position (0 when nothing matched)
// Purely combinational; the instantiating module registers the result.
// -----------------------------------------------------------------------------
module tlb_match_enc #(
    parameter  int N     = 32,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     match_i,
    output logic             found_o,
    output logic             multi_o,
    output logic [IDX_W-1:0] index_o
);

    logic             found_s;
    logic             multi_s;
    logic [IDX_W-1:0] index_s;

    // Scan from the top entry down so the last hit recorded is the lowest one;
    // a hit seen while another is already recorded flags a multi-match.
    always_comb begin
        found_s = 1'b0;
        multi_s = 1'b0;
        index_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            multi_s = multi_s | (found_s & match_i[i]);
            found_s = found_s | match_i[i];
            index_s = match_i[i] ? IDX_W'(i) : index_s;
        end
    end

    assign found_o = found_s;
    assign multi_o = multi_s;
    assign index_o = index_s;

endmodule

// File: rtl/tlb_reg.sv
// -----------------------------------------------------------------------------
// tlb_reg
// Registered-output TLB with NUM_ENTRIES dual-page entries.
//   clk, reset            : clock, synchronous active-high reset
//   s0_*/s1_*             : two independent search ports; req in, results
//                           (rvalid/found/multi/index/pfn/c/d/v) one cycle later
//   we, w_use_random, w_* : entry write (TLBWI at w_index, TLBWR at random)
//   r_req, r_index, r_*   : registered entry read (TLBR), one cycle latency
//   wired_we, wired       : Wired register load (also restarts random)
//   random                : current random replacement index (CP0 Random)
//   inv_all, inv_asid(_val): bulk valid-bit invalidation
// All lookups see the state before this cycle's write/invalidate.
// -----------------------------------------------------------------------------
module tlb_reg
    import tlb_pkg::*;
#(
    parameter  int NUM_ENTRIES = 32,
    parameter  int VPN2_W      = TLB_VPN2_W,
    parameter  int ASID_W      = TLB_ASID_W,
    parameter  int PFN_W       = TLB_PFN_W,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset,
    // search port 0
    input  logic                 s0_req,
    input  logic [VPN2_W-1:0]    s0_vpn2,
    input  logic                 s0_odd_page,
    input  logic [ASID_W-1:0]    s0_asid,
    output logic                 s0_rvalid,
    output logic                 s0_found,
    output logic                 s0_multi,
    output logic [IDX_W-1:0]     s0_index,
    output logic [PFN_W-1:0]     s0_pfn,
    output logic [TLB_C_W-1:0]   s0_c,
    output logic                 s0_d,
    output logic                 s0_v,
    // search port 1
    input  logic                 s1_req,
    input  logic [VPN2_W-1:0]    s1_vpn2,
    input  logic                 s1_odd_page,
    input  logic [ASID_W-1:0]    s1_asid,
    output logic                 s1_rvalid,
    output logic                 s1_found,
    output logic                 s1_multi,
    output logic [IDX_W-1:0]     s1_index,
    output logic [PFN_W-1:0]     s1_pfn,
    output logic [TLB_C_W-1:0]   s1_c,
    output logic                 s1_d,
    output logic                 s1_v,
    // write port
    input  logic                 we,
    input  logic                 w_use_random,
    input  logic [IDX_W-1:0]     w_index,
    input  logic [VPN2_W-1:0]    w_vpn2,
    input  logic [ASID_W-1:0]    w_asid,
    input  logic                 w_g,
    input  logic [PFN_W-1:0]     w_pfn0,
    input  logic [TLB_C_W-1:0]   w_c0,
    input  logic                 w_d0,
    input  logic                 w_v0,
    input  logic [PFN_W-1:0]     w_pfn1,
    input  logic [TLB_C_W-1:0]   w_c1,
    input  logic                 w_d1,
    input  logic                 w_v1,
    // read port
    input  logic                 r_req,
    input  logic [IDX_W-1:0]     r_index,
    output logic                 r_rvalid,
    output logic [VPN2_W-1:0]    r_vpn2,
    output logic [ASID_W-1:0]    r_asid,
    output logic                 r_g,
    output logic [PFN_W-1:0]     r_pfn0,
    output logic [TLB_C_W-1:0]   r_c0,
    output logic                 r_d0,
    output logic                 r_v0,
    output logic [PFN_W-1:0]     r_pfn1,
    output logic [TLB_C_W-1:0]   r_c1,
    output logic                 r_d1,
    output logic                 r_v1,
    // wired / random / invalidate
    input  logic                 wired_we,
    input  logic [IDX_W-1:0]     wired,
    output logic [IDX_W-1:0]     random,
    input  logic                 inv_all,
    input  logic                 inv_asid,
    input  logic [ASID_W-1:0]    inv_asid_val
);

    localparam logic [IDX_W-1:0]       IDX_MAX  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
    localparam logic [NUM_ENTRIES-1:0] ONE_HOT0 = NUM_ENTRIES'(1);

    tlb_entry_t             ent_q [NUM_ENTRIES];
    tlb_entry_t             w_ent_s;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0] inv_mask_s, wr_mask_s;
    logic [IDX_W-1:0]       w_tgt_s;
    logic                   w_en_s;
    logic [IDX_W-1:0]       wired_q, wired_d;
    logic [IDX_W-1:0]       random_q, random_d;

    // Write target: TLBWR uses the random value before this cycle's advance.
    assign w_tgt_s = w_use_random ? random_q : w_index;
    assign w_en_s  = we & ~reset;

    // Pack the write-port fields into one entry word.
    always_comb begin
        w_ent_s        = '0;
        w_ent_s.vpn2   = w_vpn2;
        w_ent_s.asid   = w_asid;
        w_ent_s.g      = w_g;
        w_ent_s.p0.pfn = w_pfn0;
        w_ent_s.p0.c   = w_c0;
        w_ent_s.p0.d   = w_d0;
        w_ent_s.p0.v   = w_v0;
        w_ent_s.p1.pfn = w_pfn1;
        w_ent_s.p1.c   = w_c1;
        w_ent_s.p1.d   = w_d1;
        w_ent_s.p1.v   = w_v1;
    end

    // Entry payload storage; deliberately not reset, only valid bits are.
    always_ff @(posedge clk) begin
        if (w_en_s) begin
            ent_q[w_tgt_s] <= w_ent_s;
        end
    end

    // Valid next-state: invalidation masks are built from the stored (pre-write)
    // entries, then the write sets its bit so a same-cycle write survives.
    always_comb begin
        inv_mask_s = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            inv_mask_s[i] = inv_all |
                            (inv_asid & ~ent_q[i].g & (ent_q[i].asid == inv_asid_val));
        end
        wr_mask_s = w_en_s ? (ONE_HOT0 << w_tgt_s) : '0;
        valid_d   = (valid_q & ~inv_mask_s) | wr_mask_s;
    end

    // Valid bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Random counts down and wraps to the top once it has reached Wired;
    // loading Wired restarts it from the top.
    always_comb begin
        if (wired_we) begin
            wired_d  = wired;
            random_d = IDX_MAX;
        end else begin
            wired_d  = wired_q;
            random_d = (random_q <= wired_q) ? IDX_MAX : (random_q - IDX_ONE);
        end
    end

    // Wired / Random registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wired_q  <= '0;
            random_q <= IDX_MAX;
        end else begin
            wired_q  <= wired_d;
            random_q <= random_d;
        end
    end

    assign random = random_q;

    // Search ports packed so both can share one generate body.
    logic [1:0]             s_req_s, s_odd_s;
    logic [1:0][VPN2_W-1:0] s_vpn2_s;
    logic [1:0][ASID_W-1:0] s_asid_s;

    assign s_req_s  = {s1_req, s0_req};
    assign s_odd_s  = {s1_odd_page, s0_odd_page};
    assign s_vpn2_s = {s1_vpn2, s0_vpn2};
    assign s_asid_s = {s1_asid, s0_asid};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [NUM_ENTRIES-1:0] match_s;
        logic                   found_s, multi_s;
        logic [IDX_W-1:0]       idx_s;
        tlb_page_t              page_s;
        logic                   rvalid_q, found_q, multi_q;
        logic [IDX_W-1:0]       index_q;
        tlb_page_t              page_q;

        // Per-entry match; global entries ignore the ASID.
        always_comb begin
            match_s = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                match_s[i] = valid_q[i] & (ent_q[i].vpn2 == s_vpn2_s[p]) &
                             (ent_q[i].g | (ent_q[i].asid == s_asid_s[p]));
            end
        end

        tlb_match_enc #(.N(NUM_ENTRIES)) u_enc (
            .match_i (match_s),
            .found_o (found_s),
            .multi_o (multi_s),
            .index_o (idx_s)
        );

        // Page-group select; a miss returns all-zero fields.
        always_comb begin
            page_s = '0;
            if (!found_s) begin
                page_s = '0;
            end else if (s_odd_s[p]) begin
                page_s = ent_q[idx_s].p1;
            end else begin
                page_s = ent_q[idx_s].p0;
            end
        end

        // Result registers: captured on req, held otherwise.
        always_ff @(posedge clk) begin
            if (reset) begin
                rvalid_q <= 1'b0;
                found_q  <= 1'b0;
                multi_q  <= 1'b0;
                index_q  <= '0;
                page_q   <= '0;
            end else if (s_req_s[p]) begin
                rvalid_q <= 1'b1;
                found_q  <= found_s;
                multi_q  <= multi_s;
                index_q  <= idx_s;
                page_q   <= page_s;
            end else begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s0_rvalid = g_port[0].rvalid_q;
    assign s0_found  = g_port[0].found_q;
    assign s0_multi  = g_port[0].multi_q;
    assign s0_index  = g_port[0].index_q;
    assign s0_pfn    = g_port[0].page_q.pfn;
    assign s0_c      = g_port[0].page_q.c;
    assign s0_d      = g_port[0].page_q.d;
    assign s0_v      = g_port[0].page_q.v;
    assign s1_rvalid = g_port[1].rvalid_q;
    assign s1_found  = g_port[1].found_q;
    assign s1_multi  = g_port[1].multi_q;
    assign s1_index  = g_port[1].index_q;
    assign s1_pfn    = g_port[1].page_q.pfn;
    assign s1_c      = g_port[1].page_q.c;
    assign s1_d      = g_port[1].page_q.d;
    assign s1_v      = g_port[1].page_q.v;

    logic       r_rvalid_q;
    tlb_entry_t r_ent_q;

    // Read-port registers (TLBR).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid_q <= 1'b0;
            r_ent_q    <= '0;
        end else if (r_req) begin
            r_rvalid_q <= 1'b1;
            r_ent_q    <= ent_q[r_index];
        end else begin
            r_rvalid_q <= 1'b0;
        end
    end

    assign r_rvalid = r_rvalid_q;
    assign r_vpn2   = r_ent_q.vpn2;
    assign r_asid   = r_ent_q.asid;
    assign r_g      = r_ent_q.g;
    assign r_pfn0   = r_ent_q.p0.pfn;
    assign r_c0     = r_ent_q.p0.c;
    assign r_d0     = r_ent_q.p0.d;
    assign r_v0     = r_ent_q.p0.v;
    assign r_pfn1   = r_ent_q.p1.pfn;
    assign r_c1     = r_ent_q.p1.c;
    assign r_d1     = r_ent_q.p1.d;
    assign r_v1     = r_ent_q.p1.v;

endmodule

// File: tb/tb_tlb_reg.sv
// -----------------------------------------------------------------------------
// tb_tlb_reg
// Lock-step bench for tlb_reg: directed scenarios followed by random traffic,
// every cycle compared against a behavioural TLB model held in plain arrays.
// -----------------------------------------------------------------------------
module tb_tlb_reg;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        s0_req, s0_odd_page, s1_req, s1_odd_page;
    logic [18:0] s0_vpn2, s1_vpn2;
    logic [7:0]  s0_asid, s1_asid;
    logic        s0_rvalid, s0_found, s0_multi, s0_d, s0_v;
    logic        s1_rvalid, s1_found, s1_multi, s1_d, s1_v;
    logic [4:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        we, w_use_random, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [4:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0]  w_c0, w_c1;
    logic        r_req, r_rvalid, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [4:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        wired_we, inv_all, inv_asid;
    logic [4:0]  wired, random;
    logic [7:0]  inv_asid_val;

    always #5 clk = ~clk;

    tlb_reg dut (
        .clk(clk), .reset(reset),
        .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_rvalid(s0_rvalid), .s0_found(s0_found), .s0_multi(s0_multi), .s0_index(s0_index),
        .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_rvalid(s1_rvalid), .s1_found(s1_found), .s1_multi(s1_multi), .s1_index(s1_index),
        .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_use_random(w_use_random), .w_index(w_index), .w_vpn2(w_vpn2),
        .w_asid(w_asid), .w_g(w_g), .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_req(r_req), .r_index(r_index), .r_rvalid(r_rvalid), .r_vpn2(r_vpn2),
        .r_asid(r_asid), .r_g(r_g), .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .wired_we(wired_we), .wired(wired), .random(random),
        .inv_all(inv_all), .inv_asid(inv_asid), .inv_asid_val(inv_asid_val)
    );

    // reference model state
    int unsigned m_vpn2[N], m_asid[N], m_g[N], m_valid[N];
    int unsigned m_pfn[N][2], m_c[N][2], m_d[N][2], m_v[N][2];
    int unsigned m_wired, m_random;
    // expected registered outputs
    int unsigned e_rv[2], e_found[2], e_multi[2], e_idx[2];
    int unsigned e_pfn[2], e_c[2], e_d[2], e_v[2];
    int unsigned e_rrv, e_rvpn2, e_rasid, e_rg;
    int unsigned e_rpfn[2], e_rc[2], e_rd[2], e_rv_bit[2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model lookup: scan all entries, count hits, keep the first.
    task automatic m_search(input int unsigned vpn, input int unsigned asid, input int unsigned odd,
                            output int unsigned f, output int unsigned mu, output int unsigned ix,
                            output int unsigned pf, output int unsigned cc,
                            output int unsigned dd, output int unsigned vv);
        int hits = 0;
        f = 0; mu = 0; ix = 0; pf = 0; cc = 0; dd = 0; vv = 0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] == 1 && m_vpn2[i] == vpn && (m_g[i] == 1 || m_asid[i] == asid)) begin
                hits++;
                if (hits == 1) begin
                    ix = i; pf = m_pfn[i][odd]; cc = m_c[i][odd];
                    dd = m_d[i][odd]; vv = m_v[i][odd];
                end
            end
        end
        f  = (hits > 0) ? 1 : 0;
        mu = (hits > 1) ? 1 : 0;
    endtask

    task automatic clear_strobes();
        reset = 1'b0; s0_req = 1'b0; s1_req = 1'b0; we = 1'b0; w_use_random = 1'b0;
        r_req = 1'b0; wired_we = 1'b0; inv_all = 1'b0; inv_asid = 1'b0;
    endtask

    // One clock: predict from the pre-edge model, update the model, clock, compare.
    task automatic step();
        int unsigned req[2], vpn[2], asid[2], odd[2];
        int unsigned tgt;
        req = '{s0_req, s1_req}; vpn = '{s0_vpn2, s1_vpn2};
        asid = '{s0_asid, s1_asid}; odd = '{s0_odd_page, s1_odd_page};
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                e_rv[p] = 0; e_found[p] = 0; e_multi[p] = 0; e_idx[p] = 0;
                e_pfn[p] = 0; e_c[p] = 0; e_d[p] = 0; e_v[p] = 0;
                e_rpfn[p] = 0; e_rc[p] = 0; e_rd[p] = 0; e_rv_bit[p] = 0;
            end
            e_rrv = 0; e_rvpn2 = 0; e_rasid = 0; e_rg = 0;
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_wired = 0; m_random = N - 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] == 1) begin
                    e_rv[p] = 1;
                    m_search(vpn[p], asid[p], odd[p], e_found[p], e_multi[p], e_idx[p],
                             e_pfn[p], e_c[p], e_d[p], e_v[p]);
                end else begin
                    e_rv[p] = 0;
                end
            end
            if (r_req) begin
                e_rrv = 1; e_rvpn2 = m_vpn2[r_index]; e_rasid = m_asid[r_index]; e_rg = m_g[r_index];
                for (int k = 0; k < 2; k++) begin
                    e_rpfn[k] = m_pfn[r_index][k]; e_rc[k] = m_c[r_index][k];
                    e_rd[k] = m_d[r_index][k]; e_rv_bit[k] = m_v[r_index][k];
                end
            end else begin
                e_rrv = 0;
            end
            tgt = w_use_random ? m_random : w_index;
            if (inv_all) begin
                for (int i = 0; i < N; i++) m_valid[i] = 0;
            end else if (inv_asid) begin
                for (int i = 0; i < N; i++)
                    if (m_g[i] == 0 && m_asid[i] == inv_asid_val) m_valid[i] = 0;
            end
            if (we) begin
                m_vpn2[tgt] = w_vpn2; m_asid[tgt] = w_asid; m_g[tgt] = w_g; m_valid[tgt] = 1;
                m_pfn[tgt][0] = w_pfn0; m_c[tgt][0] = w_c0; m_d[tgt][0] = w_d0; m_v[tgt][0] = w_v0;
                m_pfn[tgt][1] = w_pfn1; m_c[tgt][1] = w_c1; m_d[tgt][1] = w_d1; m_v[tgt][1] = w_v1;
            end
            if (wired_we) begin
                m_wired = wired; m_random = N - 1;
            end else if (m_random <= m_wired) begin
                m_random = N - 1;
            end else begin
                m_random = m_random - 1;
            end
        end
        @(posedge clk);
        #1;
        chk("random", random, m_random);
        chk("s0_rvalid", s0_rvalid, e_rv[0]);  chk("s1_rvalid", s1_rvalid, e_rv[1]);
        chk("s0_found", s0_found, e_found[0]); chk("s1_found", s1_found, e_found[1]);
        chk("s0_multi", s0_multi, e_multi[0]); chk("s1_multi", s1_multi, e_multi[1]);
        chk("s0_index", s0_index, e_idx[0]);   chk("s1_index", s1_index, e_idx[1]);
        chk("s0_pfn", s0_pfn, e_pfn[0]);       chk("s1_pfn", s1_pfn, e_pfn[1]);
        chk("s0_c", s0_c, e_c[0]);             chk("s1_c", s1_c, e_c[1]);
        chk("s0_d", s0_d, e_d[0]);             chk("s1_d", s1_d, e_d[1]);
        chk("s0_v", s0_v, e_v[0]);             chk("s1_v", s1_v, e_v[1]);
        chk("r_rvalid", r_rvalid, e_rrv);
        chk("r_vpn2", r_vpn2, e_rvpn2); chk("r_asid", r_asid, e_rasid); chk("r_g", r_g, e_rg);
        chk("r_pfn0", r_pfn0, e_rpfn[0]); chk("r_c0", r_c0, e_rc[0]);
        chk("r_d0", r_d0, e_rd[0]);       chk("r_v0", r_v0, e_rv_bit[0]);
        chk("r_pfn1", r_pfn1, e_rpfn[1]); chk("r_c1", r_c1, e_rc[1]);
        chk("r_d1", r_d1, e_rd[1]);       chk("r_v1", r_v1, e_rv_bit[1]);
        clear_strobes();
    endtask

    task automatic wr(input int unsigned idx, input int unsigned vpn, input int unsigned asid,
                      input int unsigned g, input int unsigned pfn0, input int unsigned pfn1);
        we = 1'b1; w_use_random = 1'b0; w_index = 5'(idx);
        w_vpn2 = 19'(vpn); w_asid = 8'(asid); w_g = 1'(g);
        w_pfn0 = 20'(pfn0); w_c0 = 3'(pfn0); w_d0 = 1'b1; w_v0 = 1'b1;
        w_pfn1 = 20'(pfn1); w_c1 = 3'(pfn1); w_d1 = 1'b0; w_v1 = 1'b1;
    endtask

    task automatic srch(input int p, input int unsigned vpn, input int unsigned asid,
                        input int unsigned odd);
        if (p == 0) begin
            s0_req = 1'b1; s0_vpn2 = 19'(vpn); s0_asid = 8'(asid); s0_odd_page = 1'(odd);
        end else begin
            s1_req = 1'b1; s1_vpn2 = 19'(vpn); s1_asid = 8'(asid); s1_odd_page = 1'(odd);
        end
    endtask

    initial begin
        clear_strobes();
        s0_vpn2 = '0; s1_vpn2 = '0; s0_asid = '0; s1_asid = '0; s0_odd_page = 1'b0; s1_odd_page = 1'b0;
        w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0; w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0;
        w_v0 = 1'b0; w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0; r_index = '0;
        wired = '0; inv_asid_val = '0;
        for (int i = 0; i < N; i++) m_valid[i] = 0;

        // reset state
        reset = 1'b1; step();
        reset = 1'b1; step();
        chk("rst_random", random, 31);
        chk("rst_s0_rvalid", s0_rvalid, 0);

        // empty TLB search on both ports
        srch(0, 0, 0, 0); srch(1, 0, 0, 0); step();
        chk("empty_found", s0_found, 0);
        chk("empty_rvalid", s1_rvalid, 1);

        // give every entry defined contents, then drop them all
        for (int i = 0; i < N; i++) begin
            wr(i, 32'h70000 + i, i, 0, 32'h100 + i, 32'h200 + i); step();
        end
        inv_all = 1'b1; step();

        // basic hit / ASID miss / global hit
        wr(5, 32'h12345, 3, 0, 32'hABCDE, 32'h11111); step();
        srch(0, 32'h12345, 3, 0); step();
        chk("idx5_found", s0_found, 1); chk("idx5_index", s0_index, 5); chk("idx5_pfn", s0_pfn, 20'hABCDE);
        srch(0, 32'h12345, 4, 0); step();
        chk("asid_miss", s0_found, 0);
        wr(5, 32'h12345, 3, 1, 32'hABCDE, 32'h11111); step();
        srch(0, 32'h12345, 4, 1); step();
        chk("global_hit", s0_found, 1); chk("odd_pfn", s0_pfn, 20'h11111);

        // multi-hit
        wr(2, 32'h2AAAA, 0, 1, 32'h22222, 32'h3); step();
        wr(9, 32'h2AAAA, 0, 1, 32'h99999, 32'h4); step();
        srch(1, 32'h2AAAA, 7, 0); step();
        chk("multi_found", s1_found, 1); chk("multi_index", s1_index, 2); chk("multi_flag", s1_multi, 1);

        // wired / random and TLBWR
        wired_we = 1'b1; wired = 5'd28; step();
        chk("wired_r31", random, 31);
        step();
        chk("wired_r30", random, 30);
        we = 1'b1; w_use_random = 1'b1; w_vpn2 = 19'h3CCCC; w_asid = 8'h5; w_g = 1'b0;
        w_pfn0 = 20'h0F00D; w_pfn1 = 20'h0BEEF; step();
        chk("wired_r29", random, 29);
        step();
        chk("wired_r28", random, 28);
        r_req = 1'b1; r_index = 5'd30; step();
        chk("wired_wrap", random, 31);
        chk("tlbwr_vpn2", r_vpn2, 19'h3CCCC); chk("tlbwr_rvalid", r_rvalid, 1);
        wired_we = 1'b1; wired = 5'd0; step();

        // read-before-write
        wr(11, 32'h05555, 0, 1, 32'h5, 32'h6); srch(0, 32'h05555, 0, 0); step();
        chk("rbw_miss", s0_found, 0);
        srch(0, 32'h05555, 0, 0); step();
        chk("rbw_hit", s0_found, 1);

        // ASID invalidate, then inv_all with same-cycle write
        wr(1, 32'h01111, 3, 0, 32'h1, 32'h1); step();
        wr(4, 32'h04444, 3, 1, 32'h4, 32'h4); step();
        inv_asid = 1'b1; inv_asid_val = 8'h3; step();
        srch(0, 32'h01111, 3, 0); srch(1, 32'h04444, 3, 0); step();
        chk("inv_asid_miss", s0_found, 0); chk("inv_asid_glob", s1_found, 1);
        inv_all = 1'b1; wr(7, 32'h07777, 0, 1, 32'h7, 32'h7); step();
        srch(0, 32'h07777, 0, 0); srch(1, 32'h04444, 3, 0); step();
        chk("inv_all_keep7", s0_found, 1); chk("inv_all_gone", s1_found, 0);

        // reset during a request discards the result
        srch(0, 32'h07777, 0, 0); reset = 1'b1; step();
        chk("rst_mid_rvalid", s0_rvalid, 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(99) == 0);
            if ($urandom_range(1) == 1) srch(0, 32'h100 + $urandom_range(7), $urandom_range(3), $urandom_range(1));
            if ($urandom_range(1) == 1) srch(1, 32'h100 + $urandom_range(7), $urandom_range(3), $urandom_range(1));
            if ($urandom_range(9) < 3) begin
                wr($urandom_range(31), 32'h100 + $urandom_range(7), $urandom_range(3),
                   $urandom_range(1), $urandom, $urandom);
                w_use_random = 1'($urandom_range(1));
            end
            r_req = 1'($urandom_range(1)); r_index = 5'($urandom_range(31));
            inv_all = ($urandom_range(49) == 0);
            inv_asid = ($urandom_range(32) == 0); inv_asid_val = 8'($urandom_range(3));
            wired_we = ($urandom_range(32) == 0); wired = 5'($urandom_range(31));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlb_reg.md
# tlb_reg

Parametrised, registered-output successor to the 16-entry combinational TLB. It holds NUM_ENTRIES dual-page entries with per-entry valid bits cleared on reset, and answers two independent search ports and one read port with one cycle of latency. It adds a hardware random-replacement index bounded below by a Wired register, bulk invalidation (all entries or one ASID), and multi-hit detection. It sits between the fetch/memory-stage address translation logic and the CP0 TLB instruction path (TLBP/TLBR/TLBWI/TLBWR).

## Interface

Parameters:
- NUM_ENTRIES, 32: entry count; power of two, 4..64. IDX_W = $clog2(NUM_ENTRIES).
- VPN2_W, 19: even/odd page-pair virtual page number width.
- ASID_W, 8: address-space ID width.
- PFN_W, 20: physical frame number width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- s0_req, s1_req  in  1  search request strobe, per port.
- s0_vpn2, s1_vpn2  in  VPN2_W  search VPN2.
- s0_odd_page, s1_odd_page  in  1  selects page-1 fields.
- s0_asid, s1_asid  in  ASID_W  search ASID.
- s0_rvalid, s1_rvalid  out  1  result valid, one cycle after req.
- s0_found, s1_found  out  1  at least one valid entry matched.
- s0_multi, s1_multi  out  1  more than one entry matched.
- s0_index, s1_index  out  IDX_W  lowest matching index.
- s0_pfn, s1_pfn  out  PFN_W; s0_c, s1_c  out  3; s0_d, s1_d  out  1; s0_v, s1_v  out  1: selected page fields.
- we  in  1  entry write.
- w_use_random  in  1  1: write at the random index (TLBWR); 0: write at w_index.
- w_index  in  IDX_W; w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1: entry contents.
- r_req  in  1; r_index  in  IDX_W; r_rvalid  out  1; r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out: registered read.
- wired_we  in  1; wired  in  IDX_W: Wired register write.
- random  out  IDX_W  current random index (CP0 Random).
- inv_all  in  1  clear every valid bit.
- inv_asid  in  1; inv_asid_val  in  ASID_W: clear valid on non-global entries whose ASID equals inv_asid_val.

## Operation

- Entry match: valid[i] && vpn2 equal && (g[i] || asid equal). Entries with valid=0 never match.
- found = OR of matches; index = lowest matching index; multi = popcount(match) > 1. Page fields come from the pfn1/c1/d1/v1 group when odd_page=1, else the group-0 fields. When found=0, index and fields are 0.
- Write: the target index is random when w_use_random=1, else w_index. All fields are stored and valid is set to 1.
- Wired/Random: a wired register and a random counter, both IDX_W wide.
  - Random decrements every cycle.
  - When random <= wired, the next value is NUM_ENTRIES-1.
  - wired_we loads wired and forces random to NUM_ENTRIES-1.
  - With wired = NUM_ENTRIES-1, random holds at NUM_ENTRIES-1.
- Invalidate: takes effect in one cycle. Only the valid bits change; the other fields keep their values.
- Priority in a cycle, highest first: reset, invalidate (inv_all or inv_asid), write. A write in the same cycle as an invalidate leaves the written entry valid.
- Reset values:
  - All valid bits 0, wired 0, random NUM_ENTRIES-1.
  - All rvalid outputs 0; all result registers 0.
  - Other entry fields are not reset.

## Timing

- Search and read latency is exactly 1 cycle. req sampled at edge N gives registered results and rvalid=1 during cycle N+1.
- rvalid is 0 in any cycle that does not follow a req. There is no backpressure, so a new req is accepted every cycle.
- Results are held until the next req is accepted.
- Same-cycle write and search/read use pre-write contents (read-before-write). The new entry is visible to requests sampled at edge N+1 or later.
- Same-cycle invalidate and search also see the pre-invalidate state.
- random advances every cycle, including cycles with a TLBWR; the TLBWR uses the pre-advance value.
- reset asserted mid-request: rvalid is 0 in the next cycle and the pending result is discarded.

## Structure

- Shared package tlb_pkg holds:
  - the entry struct (vpn2, asid, g, and two page groups of pfn/c/d/v);
  - the page-group struct;
  - the cache-attribute width constant.
- One sub-module, tlb_match_enc: match vector in; found, multi, and lowest index out. It is instantiated once per search port.
- The random/wired logic stays in the top module.

## Test plan

- Reset, then search vpn2=0x00000 asid=0 on both ports -> found=0, multi=0, rvalid=1 one cycle after req; random=31.
- Write index 5 {vpn2=0x12345, asid=0x3, g=0, pfn0=0xABCDE, pfn1=0x11111, v0=1}. Search with asid 0x3, odd=0 -> found=1, index=5, pfn=0xABCDE. Search with asid 0x4 -> found=0. Rewrite with g=1, then search with asid 0x4 -> found=1.
- Write index 2 and 9 with the same vpn2 and g=1 -> found=1, index=2, multi=1.
- wired_we with wired=28 -> random steps 31,30,29,28,31,... Issue TLBWR while random=30 -> r_req index 30 returns the written entry.
- Search issued in the same cycle as a write to the matching vpn2 -> found=0; the same search one cycle later -> found=1.
- Entries with asid 0x3 (g=0) at index 1 and asid 0x3 (g=1) at index 4, then inv_asid 0x3 -> the index-1 search misses and the index-4 search hits. inv_all plus a same-cycle write to index 7 -> only index 7 is found.
